// File: rtl/svm_knn_acc_pkg.sv
// Shared types and constants for the stress-accelerator job sequencer.
package svm_knn_acc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_START,
    ST_WAIT,
    ST_CLEAR,
    ST_RESP
  } seq_state_t;

  localparam logic [31:0] ADDR_OP    = 32'h0000_0000;
  localparam logic [31:0] ADDR_START = 32'h0000_0004;

  localparam logic [1:0] MODE_KNN  = 2'b01;
  localparam logic [1:0] MODE_SVM  = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

endpackage

// File: rtl/svm_knn_seq_bus_wr.sv
// Single-cycle register write driver: a request in one cycle becomes a
// one-cycle registered bus write in the next; the bus idles at all-zero.
module svm_knn_seq_bus_wr (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        wr_req,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic        acc_enable,
  output logic        acc_write,
  output logic [31:0] acc_addr,
  output logic [31:0] acc_wdata
);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      acc_enable <= 1'b0;
      acc_write  <= 1'b0;
      acc_addr   <= '0;
      acc_wdata  <= '0;
    end else begin
      acc_enable <= wr_req;
      acc_write  <= wr_req;
      acc_addr   <= wr_req ? addr : '0;
      acc_wdata  <= wr_req ? data : '0;
    end
  end

endmodule

// File: rtl/svm_knn_acc_seq.sv
// Job sequencer for the stress-detection accelerator register bus.
// Optional WAIT watchdog enabled by defining SVM_KNN_SEQ_TIMEOUT_EN.
module svm_knn_acc_seq
  import svm_knn_acc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [1:0]       job_mode,
  input  logic             job_and,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_stress,
  output logic             res_err,
  output logic             busy,
  output logic [CNT_W-1:0] job_count,
  output logic             acc_enable,
  output logic             acc_write,
  output logic [31:0]      acc_addr,
  output logic [31:0]      acc_wdata,
  input  logic             acc_valid,
  input  logic             acc_stress
);

  seq_state_t  state;
  logic [1:0]  mode_q;
  logic        mode_legal;
  logic        timeout_hit;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  assign mode_legal = job_mode inside {MODE_KNN, MODE_SVM, MODE_BOTH};

`ifdef SVM_KNN_SEQ_TIMEOUT_EN
  localparam int WDOG_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WDOG_W-1:0] wait_cnt;

  // Cleared while entering WAIT so the first WAIT cycle sees zero.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)
      wait_cnt <= '0;
    else if (state == ST_START)
      wait_cnt <= '0;
    else if (state == ST_WAIT)
      wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout_hit = (wait_cnt == WDOG_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  // Writes are requested one cycle ahead so the registered bus lines up with the state.
  always_comb begin
    wr_req  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state)
      ST_IDLE: if (job_valid && mode_legal) begin
        wr_req  = 1'b1;
        wr_addr = ADDR_OP;
        wr_data = {31'b0, job_and};
      end
      ST_CFG: begin
        wr_req  = 1'b1;
        wr_addr = ADDR_START;
        wr_data = {30'b0, mode_q};
      end
      ST_WAIT: if (acc_valid || timeout_hit) begin
        wr_req  = 1'b1;
        wr_addr = ADDR_START;
        wr_data = '0;
      end
      default: ;
    endcase
  end

  svm_knn_seq_bus_wr u_bus_wr (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .wr_req     (wr_req),
    .addr       (wr_addr),
    .data       (wr_data),
    .acc_enable (acc_enable),
    .acc_write  (acc_write),
    .acc_addr   (acc_addr),
    .acc_wdata  (acc_wdata)
  );

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state      <= ST_IDLE;
      mode_q     <= '0;
      job_ready  <= 1'b1;
      busy       <= 1'b0;
      res_valid  <= 1'b0;
      res_stress <= 1'b0;
      res_err    <= 1'b0;
      job_count  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (job_valid) begin
          mode_q    <= job_mode;
          job_ready <= 1'b0;
          busy      <= 1'b1;
          if (mode_legal) begin
            state <= ST_CFG;
          end else begin
            state      <= ST_RESP;
            res_valid  <= 1'b1;
            res_err    <= 1'b1;
            res_stress <= 1'b0;
          end
        end
        ST_CFG:   state <= ST_START;
        ST_START: state <= ST_WAIT;
        ST_WAIT: begin
          // A result arriving on the expiry cycle takes priority over the watchdog.
          if (acc_valid) begin
            res_stress <= acc_stress;
            res_err    <= 1'b0;
            state      <= ST_CLEAR;
          end else if (timeout_hit) begin
            res_stress <= 1'b0;
            res_err    <= 1'b1;
            state      <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          res_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: if (res_ready) begin
          res_valid <= 1'b0;
          job_count <= job_count + 1'b1;
          job_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_svm_knn_acc_seq.sv
// Directed bench for svm_knn_acc_seq; timeout scenario built with SVM_KNN_SEQ_TIMEOUT_EN.
module tb_svm_knn_acc_seq;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        job_valid, job_and, res_ready, acc_valid, acc_stress;
  logic [1:0]  job_mode;
  logic        job_ready, res_valid, res_stress, res_err, busy;
  logic [15:0] job_count;
  logic        acc_enable, acc_write;
  logic [31:0] acc_addr, acc_wdata;

  int checks = 0;
  int errors = 0;
  int en_pulses = 0;

  svm_knn_acc_seq #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .job_valid(job_valid), .job_ready(job_ready), .job_mode(job_mode), .job_and(job_and),
    .res_valid(res_valid), .res_ready(res_ready), .res_stress(res_stress), .res_err(res_err),
    .busy(busy), .job_count(job_count),
    .acc_enable(acc_enable), .acc_write(acc_write), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
    .acc_valid(acc_valid), .acc_stress(acc_stress)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (acc_enable) en_pulses <= en_pulses + 1;

  // Inputs change and outputs are sampled on the falling edge; one call = next cycle.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic test_reset();
    RESETn = 1'b0; job_valid = 0; job_mode = 0; job_and = 0;
    res_ready = 0; acc_valid = 0; acc_stress = 0;
    tick(2);
    checks++;
    if ({job_ready, busy, res_valid, res_stress, res_err, job_count} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      errors++; $display("FAIL reset_ctrl: got rdy=%b busy=%b rv=%b rs=%b re=%b cnt=%0d, want 1 0 0 0 0 0",
        job_ready, busy, res_valid, res_stress, res_err, job_count);
    end
    checks++;
    if ({acc_enable, acc_write, acc_addr, acc_wdata} !== 66'd0) begin
      errors++; $display("FAIL reset_bus: got en=%b wr=%b a=%h d=%h, want all 0", acc_enable, acc_write, acc_addr, acc_wdata);
    end
    RESETn = 1'b1;
    tick(1);
  endtask

  task automatic test_knn();
    job_valid = 1; job_mode = 2'b01; job_and = 0;      // cycle 0
    tick(1); job_valid = 0;                            // cycle 1
    checks++;
    if ({acc_enable, acc_write, acc_addr, acc_wdata, job_ready, busy} !== {1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL knn_cfg: got en=%b a=%h d=%h rdy=%b busy=%b, want en=1 a=0 d=0 rdy=0 busy=1",
        acc_enable, acc_addr, acc_wdata, job_ready, busy);
    end
    tick(1);                                           // cycle 2
    checks++;
    if ({acc_enable, acc_write, acc_addr, acc_wdata} !== {1'b1, 1'b1, 32'h4, 32'h1}) begin
      errors++; $display("FAIL knn_start: got en=%b a=%h d=%h, want en=1 a=4 d=1", acc_enable, acc_addr, acc_wdata);
    end
    tick(1);                                           // cycle 3
    checks++;
    if (acc_enable !== 1'b0 || acc_addr !== 32'h0) begin
      errors++; $display("FAIL knn_wait_idlebus: got en=%b a=%h, want 0 0", acc_enable, acc_addr);
    end
    tick(3);                                           // cycle 6
    acc_valid = 1; acc_stress = 1;
    tick(1);                                           // cycle 7
    acc_valid = 0; acc_stress = 0;
    checks++;
    if ({acc_enable, acc_write, acc_addr, acc_wdata, res_valid} !== {1'b1, 1'b1, 32'h4, 32'h0, 1'b0}) begin
      errors++; $display("FAIL knn_clear: got en=%b a=%h d=%h rv=%b, want en=1 a=4 d=0 rv=0",
        acc_enable, acc_addr, acc_wdata, res_valid);
    end
    tick(1);                                           // cycle 8
    checks++;
    if ({res_valid, res_stress, res_err, acc_enable} !== 4'b1100) begin
      errors++; $display("FAIL knn_resp: got rv=%b rs=%b re=%b en=%b, want 1 1 0 0", res_valid, res_stress, res_err, acc_enable);
    end
    res_ready = 1;
    tick(1);                                           // cycle 9
    res_ready = 0;
    checks++;
    if ({job_count, res_valid, job_ready, busy} !== {16'd1, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL knn_done: got cnt=%0d rv=%b rdy=%b busy=%b, want 1 0 1 0", job_count, res_valid, job_ready, busy);
    end
  endtask

  task automatic test_both_and();
    job_valid = 1; job_mode = 2'b11; job_and = 1;      // cycle 0
    tick(1); job_valid = 0;                            // cycle 1
    checks++;
    if ({acc_enable, acc_addr, acc_wdata} !== {1'b1, 32'h0, 32'h1}) begin
      errors++; $display("FAIL both_cfg: got en=%b a=%h d=%h, want en=1 a=0 d=1", acc_enable, acc_addr, acc_wdata);
    end
    tick(1);                                           // cycle 2
    checks++;
    if ({acc_enable, acc_addr, acc_wdata} !== {1'b1, 32'h4, 32'h3}) begin
      errors++; $display("FAIL both_start: got en=%b a=%h d=%h, want en=1 a=4 d=3", acc_enable, acc_addr, acc_wdata);
    end
    tick(1);                                           // cycle 3
    acc_valid = 1; acc_stress = 0;
    tick(1);                                           // cycle 4
    acc_valid = 0;
    checks++;
    if ({acc_enable, acc_addr, acc_wdata, res_valid} !== {1'b1, 32'h4, 32'h0, 1'b0}) begin
      errors++; $display("FAIL both_clear: got en=%b a=%h d=%h rv=%b, want en=1 a=4 d=0 rv=0",
        acc_enable, acc_addr, acc_wdata, res_valid);
    end
    tick(1);                                           // cycle 5
    checks++;
    if ({res_valid, res_stress, res_err} !== 3'b100) begin
      errors++; $display("FAIL both_resp: got rv=%b rs=%b re=%b, want 1 0 0", res_valid, res_stress, res_err);
    end
    res_ready = 1;
    tick(1);
    res_ready = 0;
    checks++;
    if (job_count !== 16'd2) begin
      errors++; $display("FAIL both_count: got %0d want 2", job_count);
    end
  endtask

  task automatic test_illegal();
    int p0;
    p0 = en_pulses;
    job_valid = 1; job_mode = 2'b00; job_and = 1;      // cycle 0
    tick(1); job_valid = 0;                            // cycle 1
    checks++;
    if ({res_valid, res_err, res_stress, busy, job_ready, acc_enable} !== 6'b110100) begin
      errors++; $display("FAIL illegal_resp: got rv=%b re=%b rs=%b busy=%b rdy=%b en=%b, want 1 1 0 1 0 0",
        res_valid, res_err, res_stress, busy, job_ready, acc_enable);
    end
    res_ready = 1;
    tick(1);
    res_ready = 0;
    tick(1);
    checks++;
    if (job_count !== 16'd3 || en_pulses !== p0) begin
      errors++; $display("FAIL illegal_done: got cnt=%0d pulses=%0d, want cnt=3 pulses=%0d", job_count, en_pulses, p0);
    end
  endtask

  task automatic test_back_to_back();
    job_valid = 1; job_mode = 2'b10; job_and = 0;      // cycle 0
    tick(1);                                           // cycle 1: host already presents the next job
    job_mode = 2'b01; job_and = 1;
    tick(1);                                           // cycle 2
    checks++;
    if ({acc_enable, acc_addr, acc_wdata} !== {1'b1, 32'h4, 32'h2}) begin
      errors++; $display("FAIL bp_start_latched: got en=%b a=%h d=%h, want en=1 a=4 d=2", acc_enable, acc_addr, acc_wdata);
    end
    tick(1);                                           // cycle 3
    acc_valid = 1; acc_stress = 1;
    tick(1); acc_valid = 0; acc_stress = 0;            // cycle 4
    tick(1);                                           // cycle 5
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({res_valid, res_stress, res_err, job_ready, acc_enable} !== 5'b11000) begin
        errors++; $display("FAIL bp_hold%0d: got rv=%b rs=%b re=%b rdy=%b en=%b, want 1 1 0 0 0",
          i, res_valid, res_stress, res_err, job_ready, acc_enable);
      end
      tick(1);
    end
    res_ready = 1;                                     // cycle 15: handshake
    tick(1); res_ready = 0;                            // cycle 16: IDLE, second job accepted here
    checks++;
    if ({job_ready, acc_enable, res_valid, job_count} !== {1'b1, 1'b0, 1'b0, 16'd4}) begin
      errors++; $display("FAIL bp_idle: got rdy=%b en=%b rv=%b cnt=%0d, want 1 0 0 4", job_ready, acc_enable, res_valid, job_count);
    end
    tick(1); job_valid = 0;                            // cycle 17
    checks++;
    if ({acc_enable, acc_addr, acc_wdata, job_ready} !== {1'b1, 32'h0, 32'h1, 1'b0}) begin
      errors++; $display("FAIL b2b_cfg: got en=%b a=%h d=%h rdy=%b, want en=1 a=0 d=1 rdy=0",
        acc_enable, acc_addr, acc_wdata, job_ready);
    end
    tick(1);                                           // cycle 18
    checks++;
    if ({acc_addr, acc_wdata} !== {32'h4, 32'h1}) begin
      errors++; $display("FAIL b2b_start: got a=%h d=%h, want a=4 d=1", acc_addr, acc_wdata);
    end
    tick(1); acc_valid = 1; acc_stress = 0;            // cycle 19
    tick(1); acc_valid = 0;                            // cycle 20
    tick(1);                                           // cycle 21
    checks++;
    if ({res_valid, res_stress, res_err} !== 3'b100) begin
      errors++; $display("FAIL b2b_resp: got rv=%b rs=%b re=%b, want 1 0 0", res_valid, res_stress, res_err);
    end
    res_ready = 1; tick(1); res_ready = 0;
    checks++;
    if (job_count !== 16'd5) begin
      errors++; $display("FAIL b2b_count: got %0d want 5", job_count);
    end
  endtask

`ifdef SVM_KNN_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    job_valid = 1; job_mode = 2'b01; job_and = 0;      // cycle 0
    tick(1); job_valid = 0;                            // cycle 1
    tick(9);                                           // cycle 10
    checks++;
    if (acc_enable !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL to_early: got en=%b rv=%b, want 0 0", acc_enable, res_valid);
    end
    tick(1);                                           // cycle 11
    checks++;
    if ({acc_enable, acc_addr, acc_wdata} !== {1'b1, 32'h4, 32'h0}) begin
      errors++; $display("FAIL to_clear: got en=%b a=%h d=%h, want en=1 a=4 d=0", acc_enable, acc_addr, acc_wdata);
    end
    tick(1);                                           // cycle 12
    checks++;
    if ({res_valid, res_err, res_stress} !== 3'b110) begin
      errors++; $display("FAIL to_resp: got rv=%b re=%b rs=%b, want 1 1 0", res_valid, res_err, res_stress);
    end
    res_ready = 1; tick(1); res_ready = 0;
    checks++;
    if (job_count !== 16'd6) begin
      errors++; $display("FAIL to_count: got %0d want 6", job_count);
    end
  endtask
`else
  task automatic test_long_wait();
    int p0;
    job_valid = 1; job_mode = 2'b10; job_and = 1;      // cycle 0
    tick(3); job_valid = 0;                            // cycle 3: WAIT
    p0 = en_pulses;
    tick(40);                                          // cycle 43
    checks++;
    if ({busy, res_valid, res_err} !== 3'b100 || en_pulses !== p0) begin
      errors++; $display("FAIL wait_unbounded: got busy=%b rv=%b re=%b pulses=%0d, want 1 0 0 pulses=%0d",
        busy, res_valid, res_err, en_pulses, p0);
    end
    acc_valid = 1; acc_stress = 1;
    tick(1); acc_valid = 0; acc_stress = 0;
    tick(1);
    checks++;
    if ({res_valid, res_stress, res_err} !== 3'b110) begin
      errors++; $display("FAIL wait_resp: got rv=%b rs=%b re=%b, want 1 1 0", res_valid, res_stress, res_err);
    end
    res_ready = 1; tick(1); res_ready = 0;
    checks++;
    if (job_count !== 16'd6) begin
      errors++; $display("FAIL wait_count: got %0d want 6", job_count);
    end
  endtask
`endif

  task automatic test_reset_mid_job();
    job_valid = 1; job_mode = 2'b11; job_and = 1;      // cycle 0
    tick(1); job_valid = 0;                            // cycle 1
    checks++;
    if (acc_enable !== 1'b1) begin
      errors++; $display("FAIL rst_pre_cfg: got en=%b want 1", acc_enable);
    end
    tick(3);                                           // cycle 4: WAIT
    #2 RESETn = 1'b0;
    #1;
    checks++;
    if ({job_ready, busy, res_valid, res_stress, res_err, job_count} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      errors++; $display("FAIL rst_async_ctrl: got rdy=%b busy=%b rv=%b rs=%b re=%b cnt=%0d, want 1 0 0 0 0 0",
        job_ready, busy, res_valid, res_stress, res_err, job_count);
    end
    checks++;
    if ({acc_enable, acc_write, acc_addr, acc_wdata} !== 66'd0) begin
      errors++; $display("FAIL rst_async_bus: got en=%b wr=%b a=%h d=%h, want all 0", acc_enable, acc_write, acc_addr, acc_wdata);
    end
    tick(1); RESETn = 1'b1;
    tick(1);
    job_valid = 1; job_mode = 2'b01; job_and = 0;      // cycle 0
    tick(1); job_valid = 0;                            // cycle 1
    checks++;
    if ({acc_enable, acc_addr, acc_wdata} !== {1'b1, 32'h0, 32'h0}) begin
      errors++; $display("FAIL rst_new_cfg: got en=%b a=%h d=%h, want en=1 a=0 d=0", acc_enable, acc_addr, acc_wdata);
    end
    tick(2); acc_valid = 1; acc_stress = 1;            // cycle 3
    tick(1); acc_valid = 0; acc_stress = 0;            // cycle 4
    tick(1);                                           // cycle 5
    checks++;
    if ({res_valid, res_stress, res_err} !== 3'b110) begin
      errors++; $display("FAIL rst_new_resp: got rv=%b rs=%b re=%b, want 1 1 0", res_valid, res_stress, res_err);
    end
    res_ready = 1; tick(1); res_ready = 0;
    checks++;
    if (job_count !== 16'd1) begin
      errors++; $display("FAIL rst_new_count: got %0d want 1", job_count);
    end
  endtask

  initial begin
    test_reset();
    test_knn();
    test_both_and();
    test_illegal();
    test_back_to_back();
`ifdef SVM_KNN_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/svm_knn_acc_seq.md
# svm_knn_acc_seq

Job sequencer sitting in front of the stress-detection accelerator top's register bus. It accepts one classification job at a time from a host over a valid/ready handshake. For each job it programs the logic-operation and start registers, waits for the accelerator's `valid`, captures `Stress_Out`, and clears the start bits. It then returns the result over a second valid/ready handshake.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 4096: WAIT-state watchdog limit in clock cycles. Active only with the macro in Configuration.
- `CNT_W`, default 16: width of the completed-job counter.

Ports:
- `CLK`, input, 1: the block's one clock, rising edge.
- `RESETn`, input, 1: reset, asynchronous, active-low.
- `job_valid`, input, 1: host job request.
- `job_ready`, output, 1: sequencer can accept a job. High only in IDLE.
- `job_mode`, input, 2: start mask. Bit0 = KNN, bit1 = SVM.
- `job_and`, input, 1: combine operation. 1 = AND, 0 = OR.
- `res_valid`, output, 1: result available.
- `res_ready`, input, 1: host accepts the result.
- `res_stress`, output, 1: captured stress classification.
- `res_err`, output, 1: job failed (illegal mode or timeout).
- `busy`, output, 1: high in every state except IDLE.
- `job_count`, output, `CNT_W`: jobs completed, error jobs included. Wraps modulo 2^`CNT_W`.
- `acc_enable`, output, 1: drives the accelerator `Enable`.
- `acc_write`, output, 1: drives the accelerator `write_TOP`.
- `acc_addr`, output, 32: drives the accelerator `Address`.
- `acc_wdata`, output, 32: drives the accelerator `write_data`.
- `acc_valid`, input, 1: from the accelerator `valid`.
- `acc_stress`, input, 1: from the accelerator `Stress_Out`.

## Operation
- States:
  - IDLE: waits for a job.
  - CFG: writes `ADDR_OP` with wdata = {31'b0, job_and}.
  - START: writes `ADDR_START` with wdata = {30'b0, job_mode}.
  - WAIT: waits for `acc_valid`.
  - CLEAR: writes `ADDR_START` with wdata = 0.
  - RESP: presents the result.
- Job acceptance: a job is accepted on `job_valid && job_ready`. `job_mode` and `job_and` are latched on that edge.
- Illegal mode: `job_mode == 2'b00` goes IDLE -> RESP with `res_err=1`, `res_stress=0`. No bus writes occur.
- Normal path: IDLE -> CFG -> START -> WAIT.
- Leaving WAIT: on the first cycle `acc_valid` is 1, `acc_stress` is latched into `res_stress` and the FSM goes to CLEAR.
- CLEAR -> RESP.
- RESP: hold `res_valid`, `res_stress` and `res_err` stable until `res_ready`. On the handshake, increment `job_count` and go to IDLE.
- Bus write: one cycle with `acc_enable=acc_write=1` and addr/wdata valid. In all other cycles all four `acc_*` outputs are 0.
- CLEAR is mandatory on both success and timeout. This drops the accelerator's sticky result and valid before the next job.
- `job_valid` while busy is ignored because `job_ready` is 0. The host must hold the request.
- `res_ready` is ignored outside RESP.

## Timing
- Reset values: FSM in IDLE, `job_ready=1`, `busy=0`, `res_valid=0`, `res_stress=0`, `res_err=0`, `job_count=0`, all `acc_*` outputs 0.
- Cycle-by-cycle, with the job handshake on edge 0:
  - Cycle 1: CFG write.
  - Cycle 2: START write.
  - Cycle 3 onward: WAIT.
  - `acc_valid` sampled high in cycle N -> CLEAR write in cycle N+1 -> `res_valid=1` from cycle N+2.
- Minimum job-to-result latency is 5 cycles (`acc_valid` in cycle 3).
- Illegal mode: `res_valid=1` in cycle 1.
- Back-to-back: a `res_ready` handshake in cycle M gives IDLE in cycle M+1, and a new job can be accepted there.
- Reset mid-job: returns to IDLE immediately and drops all outputs to reset values. The accelerator's own reset clears its start bits.

## Configuration
- Macro: `SVM_KNN_SEQ_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT_CYCLES - 1` with `acc_valid` low, the FSM goes to CLEAR with `res_err=1` and `res_stress=0`.
  - `acc_valid` in the same cycle as expiry wins: normal result, no error.
- Undefined: no counter. WAIT is unbounded, and `res_err` is set only for illegal mode.

## Structure
- Shared package `svm_knn_acc_pkg` holds:
  - the state enum type `seq_state_t`;
  - `ADDR_OP = 32'h0000_0000`;
  - `ADDR_START = 32'h0000_0004`;
  - the mode constants `MODE_KNN = 2'b01`, `MODE_SVM = 2'b10`, `MODE_BOTH = 2'b11`.
- Sub-module `svm_knn_seq_bus_wr`: a single-cycle register write driver. It takes `wr_req`, `addr` and `data` and registers the `acc_*` outputs.
- The FSM, watchdog and counter stay in the top.

## Test plan
- **Single KNN job.** Mode=01, and=0; `acc_valid` and `acc_stress=1` in cycle 6.
  - Bus writes: (0x0, 0) in cycle 1, (0x4, 1) in cycle 2, (0x4, 0) in cycle 7.
  - `res_valid=1`, `res_stress=1`, `res_err=0` in cycle 8; `job_count=1` after `res_ready`.
- **Both cores, AND.** Mode=11, and=1; `acc_valid` in cycle 3 with `acc_stress=0`.
  - Writes carry wdata 1 then 3.
  - `res_valid` in cycle 5 with `res_stress=0`.
- **Illegal mode.** Mode=00 -> no `acc_enable` pulses; `res_valid=1`, `res_err=1` in cycle 1; `job_count` increments.
- **Backpressure.** Hold `res_ready=0` for 10 cycles.
  - Result outputs stay stable.
  - A second `job_valid` is not accepted until the cycle after the `res_ready` handshake.
- **Timeout** (macro defined, `TIMEOUT_CYCLES=8`). `acc_valid` never rises.
  - CLEAR write in cycle 11.
  - `res_err=1`, `res_stress=0` in cycle 12.
- **Reset during WAIT.** Deassert `RESETn` mid-job.
  - All outputs return to reset values asynchronously, `job_count` included.
  - A new job after reset completes normally.
